// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: walks a 4-input combinational circuit through all 16
// input vectors and compares the captured responses against a golden table.
module truth_table_sequencer #(
   parameter int unsigned SETTLE   = 1,
   parameter logic [15:0] EXPECTED = 16'h5144
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        dut_out,
   output logic        A,
   output logic        B,
   output logic        C,
   output logic        D,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] signature,
   output logic [4:0]  mismatch_count
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [3:0] SETTLE_L = 4'(SETTLE);

   state_t      state_r;
   logic [3:0]  vec_r;
   logic [3:0]  hold_r;
   logic        busy_r;
   logic        done_r;
   logic        pass_r;
   logic [15:0] sig_r;
   logic [4:0]  mm_r;
   logic [15:0] sig_next_s;
   logic        last_hold_s;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'd0, v[i]};
      end
      return n;
   endfunction

   // Signature with the current response merged in, so the final verdict sees bit 15.
   always_comb begin
      sig_next_s         = sig_r;
      sig_next_s[vec_r]  = dut_out;
      last_hold_s        = (hold_r == SETTLE_L);
   end

   // Sequencer state, stimulus vector, hold counter and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         vec_r   <= 4'd0;
         hold_r  <= 4'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
         sig_r   <= 16'h0000;
         mm_r    <= 5'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  state_r <= ST_RUN;
                  vec_r   <= 4'd0;
                  hold_r  <= 4'd0;
                  busy_r  <= 1'b1;
                  pass_r  <= 1'b0;
                  sig_r   <= 16'h0000;
                  mm_r    <= 5'd0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (last_hold_s) begin
                  sig_r  <= sig_next_s;
                  hold_r <= 4'd0;
                  if (vec_r == 4'd15) begin
                     // Last vector: verdict is computed from the completed table.
                     state_r <= ST_IDLE;
                     vec_r   <= 4'd0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     pass_r  <= (sig_next_s == EXPECTED);
                     mm_r    <= popcount16(sig_next_s ^ EXPECTED);
                  end else begin
                     vec_r <= vec_r + 4'd1;
                  end
               end else begin
                  hold_r <= hold_r + 4'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               vec_r   <= 4'd0;
               hold_r  <= 4'd0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign A              = vec_r[3];
   assign B              = vec_r[2];
   assign C              = vec_r[1];
   assign D              = vec_r[0];
   assign busy           = busy_r;
   assign done           = done_r;
   assign pass           = pass_r;
   assign signature      = sig_r;
   assign mismatch_count = mm_r;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer: two instances (SETTLE=1 and SETTLE=0)
// driven by directed runs; a negedge monitor checks stimulus order and results.
module tb_truth_table_sequencer;

   typedef struct packed {
      logic [15:0] sig;
      logic        pass;
      logic [4:0]  mm;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start0, start1;
   int          mode0, mode1;
   logic        out0, out1;
   logic        a0, b0, c0, d0, busy0, done0, pass0;
   logic        a1, b1, c1, d1, busy1, done1, pass1;
   logic [15:0] sig0, sig1;
   logic [4:0]  mm0, mm1;

   exp_t q0[$];
   exp_t q1[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc[2];
   logic bprev[2];
   logic dprev[2];

   truth_table_sequencer #(.SETTLE(1), .EXPECTED(16'h5144)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .dut_out(out0),
      .A(a0), .B(b0), .C(c0), .D(d0), .busy(busy0), .done(done0),
      .pass(pass0), .signature(sig0), .mismatch_count(mm0));

   truth_table_sequencer #(.SETTLE(0), .EXPECTED(16'h5144)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(out1),
      .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
      .pass(pass1), .signature(sig1), .mismatch_count(mm1));

   function automatic logic model(input int m, input logic a, b, c, d);
      if (m == 1) return 1'b0;
      if (m == 2) return 1'b1;
      return (~a & c & ~d) | (a & ~c & ~d) | (b & c & ~d);
   endfunction

   function automatic exp_t mk(input logic [15:0] s, input logic p, input logic [4:0] m);
      exp_t e;
      e.sig  = s;
      e.pass = p;
      e.mm   = m;
      return e;
   endfunction

   always_comb begin
      out0 = model(mode0, a0, b0, c0, d0);
      out1 = model(mode1, a1, b1, c1, d1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic mon(input int k, input logic [3:0] v, input logic busy, input logic done,
                      input logic pass, input logic [15:0] sig, input logic [4:0] mm,
                      input int settle);
      exp_t e;
      if (!rst_n) begin
         bprev[k] = 1'b0;
         dprev[k] = 1'b0;
         cyc[k]   = 0;
         return;
      end
      if (busy) begin
         if (!bprev[k]) begin
            cyc[k] = 0;
            check($sformatf("dut%0d_clear_sig", k), 32'(sig), 32'h0);
            check($sformatf("dut%0d_clear_pass", k), 32'(pass), 32'h0);
            check($sformatf("dut%0d_clear_mm", k), 32'(mm), 32'h0);
         end else begin
            cyc[k]++;
         end
         check($sformatf("dut%0d_vector", k), 32'(v), 32'(cyc[k] / (settle + 1)));
      end else begin
         check($sformatf("dut%0d_idle_vector", k), 32'(v), 32'h0);
      end
      if (done) begin
         check($sformatf("dut%0d_done_pulse", k), 32'(dprev[k]), 32'h0);
         check($sformatf("dut%0d_busy_cycles", k), 32'(cyc[k] + 1), 32'(16 * (settle + 1)));
         if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            check($sformatf("dut%0d_unexpected_done", k), 32'h1, 32'h0);
         end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("dut%0d_signature", k), 32'(sig), 32'(e.sig));
            check($sformatf("dut%0d_pass", k), 32'(pass), 32'(e.pass));
            check($sformatf("dut%0d_mismatch_count", k), 32'(mm), 32'(e.mm));
         end
      end
      bprev[k] = busy;
      dprev[k] = done;
   endtask

   // Monitor: samples both instances on the falling edge.
   always @(negedge clk) begin
      mon(0, {a0, b0, c0, d0}, busy0, done0, pass0, sig0, mm0, 1);
      mon(1, {a1, b1, c1, d1}, busy1, done1, pass1, sig1, mm1, 0);
   end

   task automatic pulse0();
      @(posedge clk); #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 200; i++) begin
         if (q0.size() == 0 && q1.size() == 0) break;
         @(posedge clk);
      end
      check("scoreboard_drain", 32'(q0.size() + q1.size()), 32'h0);
      @(posedge clk);
   endtask

   task automatic check_reset0(input string tag);
      check({tag, "_abcd"}, 32'({a0, b0, c0, d0}), 32'h0);
      check({tag, "_busy"}, 32'(busy0), 32'h0);
      check({tag, "_done"}, 32'(done0), 32'h0);
      check({tag, "_pass"}, 32'(pass0), 32'h0);
      check({tag, "_sig"}, 32'(sig0), 32'h0);
      check({tag, "_mm"}, 32'(mm0), 32'h0);
   endtask

   initial begin
      bool_init: begin
         rst_n  = 1'b0;
         start0 = 1'b0;
         start1 = 1'b0;
         mode0  = 0;
         mode1  = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset0("reset");
      check("reset_busy1", 32'(busy1), 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Golden run; a start pulse mid-run must be ignored.
      q0.push_back(mk(16'h5144, 1'b1, 5'd0));
      pulse0();
      repeat (10) @(posedge clk);
      #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      wait_empty();

      // Stuck-at-0 response, then results must hold in idle.
      mode0 = 1;
      q0.push_back(mk(16'h0000, 1'b0, 5'd5));
      pulse0();
      wait_empty();
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("hold_sig", 32'(sig0), 32'h0000);
      check("hold_pass", 32'(pass0), 32'h0);
      check("hold_mm", 32'(mm0), 32'd5);

      // Stuck-at-1 response.
      mode0 = 2;
      q0.push_back(mk(16'hFFFF, 1'b0, 5'd11));
      pulse0();
      wait_empty();

      // SETTLE=0 instance, golden model.
      q1.push_back(mk(16'h5144, 1'b1, 5'd0));
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      wait_empty();

      // Reset while vector 7 is driven aborts the run without done.
      mode0 = 0;
      q0.push_back(mk(16'h5144, 1'b1, 5'd0));
      pulse0();
      begin
         bit found;
         found = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({a0, b0, c0, d0} == 4'd7) begin
               found = 1'b1;
               break;
            end
         end
         check("reach_vector7", 32'(found), 32'h1);
      end
      @(posedge clk); #1 rst_n = 1'b0;
      void'(q0.pop_back());
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check_reset0("midrun_reset");
      repeat (40) @(posedge clk);
      q0.push_back(mk(16'h5144, 1'b1, 5'd0));
      pulse0();
      wait_empty();

      // Start held high: one run, then a new run accepted in the done cycle.
      q0.push_back(mk(16'h5144, 1'b1, 5'd0));
      q0.push_back(mk(16'h5144, 1'b1, 5'd0));
      @(posedge clk); #1 start0 = 1'b1;
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done0) begin
               seen = 1'b1;
               break;
            end
         end
         check("held_start_first_done", 32'(seen), 32'h1);
      end
      @(posedge clk); #1 start0 = 1'b0;
      wait_empty();
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
